// File: rtl/lcd_pkg.sv
// Shared types and nibble attribute constants for the LCD transmitter arbiter.
// Imported by the arbiter FSM and the testbench.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_R0_SEND  = 3'd1,
      ST_R0_WAIT  = 3'd2,
      ST_R1H_SEND = 3'd3,
      ST_R1H_WAIT = 3'd4,
      ST_R1L_SEND = 3'd5,
      ST_R1L_WAIT = 3'd6,
      ST_HOLD     = 3'd7
   } arb_state_t;

   localparam logic RS_CMD    = 1'b0;
   localparam logic RS_DATA   = 1'b1;
   localparam logic RB_POLL   = 1'b1;
   localparam logic RB_NOPOLL = 1'b0;
   localparam logic MODE_4BIT = 1'b1;

   function automatic logic is_send(input arb_state_t s);
      return (s == ST_R0_SEND) || (s == ST_R1H_SEND) || (s == ST_R1L_SEND);
   endfunction

   function automatic logic is_wait(input arb_state_t s);
      return (s == ST_R0_WAIT) || (s == ST_R1H_WAIT) || (s == ST_R1L_WAIT);
   endfunction

   function automatic logic is_active(input arb_state_t s);
      return (s != ST_IDLE) && (s != ST_HOLD);
   endfunction

endpackage

// File: rtl/lcd_watchdog.sv
// Transaction watchdog: counts wait cycles after a transmitter start and flags
// expiry on the last allowed cycle. Saturates at the limit, so it never wraps.
module lcd_watchdog #(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (enable_i && (count_q != LAST))
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign expire_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates the 4-bit LCD transmitter between the init sequencer (R0, nibbles)
// and the text writer (R1, bytes split high/low), with a per-transaction watchdog.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int HOLDOFF        = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       init_done_in,
   input  logic       r0_valid,
   input  logic [3:0] r0_nibble,
   input  logic       r0_mode4bit,
   input  logic       r0_read_busy,
   output logic       r0_done,
   input  logic       r1_valid,
   input  logic [7:0] r1_byte,
   input  logic       r1_rs,
   output logic       r1_done,
   output logic       tx_start,
   output logic [3:0] tx_nibble,
   output logic       tx_rs,
   output logic       tx_mode4bit,
   output logic       tx_read_busy,
   input  logic       tx_done,
   output logic       busy,
   output logic       timeout_err
);

   // HOLDOFF is assumed >= 1; the hold counter runs 0 .. HOLDOFF-1.
   localparam int                HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

   arb_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        low_q, low_d;
   logic              tx_start_q, tx_start_d;
   logic [3:0]        nibble_q, nibble_d;
   logic              rs_q, rs_d;
   logic              mode_q, mode_d;
   logic              rb_q, rb_d;
   logic              r0_done_q, r0_done_d;
   logic              r1_done_q, r1_done_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              wd_expire;

   lcd_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .CLK      (CLK),
      .RESET    (RESET),
      .clear_i  (tx_start_q),
      .enable_i (is_wait(state_q)),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      low_d     = low_q;
      nibble_d  = nibble_q;
      rs_d      = rs_q;
      mode_d    = mode_q;
      rb_d      = rb_q;
      r0_done_d = 1'b0;
      r1_done_d = 1'b0;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (r0_valid) begin
               state_d  = ST_R0_SEND;
               nibble_d = r0_nibble;
               rs_d     = RS_CMD;
               mode_d   = r0_mode4bit;
               rb_d     = r0_read_busy;
            end else if (r1_valid && init_done_in) begin
               state_d  = ST_R1H_SEND;
               nibble_d = r1_byte[7:4];
               low_d    = r1_byte[3:0];
               rs_d     = r1_rs;
               mode_d   = MODE_4BIT;
               rb_d     = RB_NOPOLL;
            end
         end
         ST_R0_SEND:  state_d = ST_R0_WAIT;
         ST_R1H_SEND: state_d = ST_R1H_WAIT;
         ST_R1L_SEND: state_d = ST_R1L_WAIT;
         // A tx_done coinciding with expiry wins: it is tested first.
         ST_R0_WAIT: begin
            if (tx_done || wd_expire) begin
               r0_done_d = 1'b1;
               err_d     = err_q | ~tx_done;
               state_d   = ST_HOLD;
            end
         end
         ST_R1H_WAIT: begin
            if (tx_done) begin
               state_d  = ST_R1L_SEND;
               nibble_d = low_q;
               rb_d     = RB_POLL;
            end else if (wd_expire) begin
               r1_done_d = 1'b1;
               err_d     = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_R1L_WAIT: begin
            if (tx_done || wd_expire) begin
               r1_done_d = 1'b1;
               err_d     = err_q | ~tx_done;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST)
               state_d = ST_IDLE;
            else
               hold_d = hold_q + HOLD_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_HOLD) && (state_q != ST_HOLD))
         hold_d = '0;

      tx_start_d = is_send(state_d);
      busy_d     = is_active(state_d);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         low_q      <= '0;
         tx_start_q <= 1'b0;
         nibble_q   <= '0;
         rs_q       <= 1'b0;
         mode_q     <= 1'b0;
         rb_q       <= 1'b0;
         r0_done_q  <= 1'b0;
         r1_done_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         low_q      <= low_d;
         tx_start_q <= tx_start_d;
         nibble_q   <= nibble_d;
         rs_q       <= rs_d;
         mode_q     <= mode_d;
         rb_q       <= rb_d;
         r0_done_q  <= r0_done_d;
         r1_done_q  <= r1_done_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign tx_start     = tx_start_q;
   assign tx_nibble    = nibble_q;
   assign tx_rs        = rs_q;
   assign tx_mode4bit  = mode_q;
   assign tx_read_busy = rb_q;
   assign r0_done      = r0_done_q;
   assign r1_done      = r1_done_q;
   assign busy         = busy_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: transaction-level model of the
// expected tx nibble sequence and done timing, with a delay-programmable transmitter.
module tb_lcd_bus_arbiter;
   import lcd_pkg::*;

   localparam int TO = 16;
   localparam int HO = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       init_done_in = 1'b0;
   logic       r0_valid = 1'b0;
   logic [3:0] r0_nibble = '0;
   logic       r0_mode4bit = 1'b0;
   logic       r0_read_busy = 1'b0;
   logic       r1_valid = 1'b0;
   logic [7:0] r1_byte = '0;
   logic       r1_rs = 1'b0;
   logic       tx_done = 1'b0;
   logic       r0_done, r1_done, tx_start, tx_rs, tx_mode4bit, tx_read_busy, busy, timeout_err;
   logic [3:0] tx_nibble;

   lcd_bus_arbiter #(.TIMEOUT_CYCLES(TO), .HOLDOFF(HO)) dut (
      .CLK(CLK), .RESET(RESET), .init_done_in(init_done_in),
      .r0_valid(r0_valid), .r0_nibble(r0_nibble), .r0_mode4bit(r0_mode4bit),
      .r0_read_busy(r0_read_busy), .r0_done(r0_done),
      .r1_valid(r1_valid), .r1_byte(r1_byte), .r1_rs(r1_rs), .r1_done(r1_done),
      .tx_start(tx_start), .tx_nibble(tx_nibble), .tx_rs(tx_rs),
      .tx_mode4bit(tx_mode4bit), .tx_read_busy(tx_read_busy), .tx_done(tx_done),
      .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      int         cyc;
      logic [3:0] nib;
      logic       rs;
      logic       mode;
      logic       rb;
   } start_t;

   start_t starts[$];
   int     r0_dones[$];
   int     r1_dones[$];
   int     cyc = 0;
   int     done_at = -1;
   int     resp_delay = 1;
   bit     resp_en = 1'b1;
   int     n_cmp = 0;
   int     n_err = 0;

   initial forever #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Transmitter model: answers each start with tx_done resp_delay cycles later.
   initial forever begin
      @(posedge CLK);
      #1 tx_done = (cyc == done_at);
   end

   // Monitor plus requester behaviour: a requester drops valid on its done pulse.
   initial forever begin
      @(negedge CLK);
      if (tx_start === 1'b1) begin
         starts.push_back('{cyc, tx_nibble, tx_rs, tx_mode4bit, tx_read_busy});
         done_at = resp_en ? cyc + resp_delay : -1;
      end
      if (r0_done === 1'b1) begin
         r0_dones.push_back(cyc);
         r0_valid = 1'b0;
      end
      if (r1_done === 1'b1) begin
         r1_dones.push_back(cyc);
         r1_valid = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 50000 cycles");
      $fatal(1, "bench hung");
   end

   // d = 0 means the transmitter never answers.
   task automatic issue(input bit use_r1, input logic [7:0] data, input logic rs,
                        input logic mode, input logic rb, input int d,
                        output int k, output bit ok);
      int budget;
      starts.delete(); r0_dones.delete(); r1_dones.delete();
      resp_en = (d > 0);
      resp_delay = d;
      @(posedge CLK); #1;
      k = cyc;
      if (use_r1) begin
         r1_byte = data; r1_rs = rs; r1_valid = 1'b1;
      end else begin
         r0_nibble = data[3:0]; r0_mode4bit = mode; r0_read_busy = rb; r0_valid = 1'b1;
      end
      budget = 0;
      ok = 1'b0;
      while (budget < 80 && !ok) begin
         @(negedge CLK); #1;
         ok = use_r1 ? (r1_dones.size() > 0) : (r0_dones.size() > 0);
         budget++;
      end
      repeat (4) @(posedge CLK);
      #1;
      $display("txn %s data=%h rs=%0d mode=%0d rb=%0d delay=%0d req_cyc=%0d starts=%0d done=%0d",
               use_r1 ? "R1" : "R0", data, rs, mode, rb, d, k, starts.size(), ok);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++;
      if ({tx_start, tx_nibble, tx_rs, tx_mode4bit, tx_read_busy, r0_done, r1_done, busy, timeout_err} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {tx_start, tx_nibble, tx_rs, tx_mode4bit, tx_read_busy, r0_done, r1_done, busy, timeout_err});
      end
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_r0_nibble();
      int k; bit ok;
      issue(1'b0, 8'h03, RS_CMD, 1'b0, 1'b1, 5, k, ok);
      n_cmp++;
      if (!ok || starts.size() != 1) begin
         n_err++;
         $display("FAIL r0_basic_count: done=%0d starts=%0d required done=1 starts=1", ok, starts.size());
      end else begin
         n_cmp++;
         if ({starts[0].nib, starts[0].rs, starts[0].mode, starts[0].rb} !== 7'b0011_0_0_1 || starts[0].cyc != k + 1) begin
            n_err++;
            $display("FAIL r0_basic_payload: nib=%b rs=%0d mode=%0d rb=%0d cyc=%0d required 0011/0/0/1 cyc=%0d",
                     starts[0].nib, starts[0].rs, starts[0].mode, starts[0].rb, starts[0].cyc, k + 1);
         end
         n_cmp++;
         if (r0_dones[0] != starts[0].cyc + 6) begin
            n_err++;
            $display("FAIL r0_basic_done: r0_done at %0d required %0d", r0_dones[0], starts[0].cyc + 6);
         end
      end
   endtask

   task automatic test_r1_byte();
      int k; bit ok;
      init_done_in = 1'b1;
      issue(1'b1, 8'h41, RS_DATA, 1'b0, 1'b0, 3, k, ok);
      n_cmp++;
      if (!ok || starts.size() != 2 || r1_dones.size() != 1) begin
         n_err++;
         $display("FAIL r1_basic_count: done=%0d starts=%0d r1_dones=%0d required 1/2/1", ok, starts.size(), r1_dones.size());
      end else begin
         n_cmp++;
         if ({starts[0].nib, starts[0].rs, starts[0].mode, starts[0].rb} !== 7'b0100_1_1_0) begin
            n_err++;
            $display("FAIL r1_basic_high: nib=%h rs=%0d mode=%0d rb=%0d required 4/1/1/0",
                     starts[0].nib, starts[0].rs, starts[0].mode, starts[0].rb);
         end
         n_cmp++;
         if ({starts[1].nib, starts[1].rs, starts[1].mode, starts[1].rb} !== 7'b0001_1_1_1) begin
            n_err++;
            $display("FAIL r1_basic_low: nib=%h rs=%0d mode=%0d rb=%0d required 1/1/1/1",
                     starts[1].nib, starts[1].rs, starts[1].mode, starts[1].rb);
         end
      end
   endtask

   task automatic test_priority();
      int k; int budget;
      starts.delete(); r0_dones.delete(); r1_dones.delete();
      resp_en = 1'b1; resp_delay = 4;
      @(posedge CLK); #1;
      k = cyc;
      r0_nibble = 4'hC; r0_mode4bit = 1'b1; r0_read_busy = 1'b0; r0_valid = 1'b1;
      r1_byte = 8'h5A; r1_rs = RS_DATA; r1_valid = 1'b1;
      budget = 0;
      while (r1_dones.size() == 0 && budget < 150) begin @(posedge CLK); #1; budget++; end
      $display("txn priority both-raised req_cyc=%0d starts=%0d", k, starts.size());
      n_cmp++;
      if (starts.size() != 3 || r0_dones.size() != 1) begin
         n_err++;
         $display("FAIL prio_same_cycle_count: starts=%0d r0_dones=%0d required 3/1", starts.size(), r0_dones.size());
      end else begin
         n_cmp++;
         if (starts[0].nib !== 4'hC || starts[0].cyc != k + 1 || starts[1].nib !== 4'h5) begin
            n_err++;
            $display("FAIL prio_same_cycle_order: first=%h@%0d second=%h required C@%0d then 5",
                     starts[0].nib, starts[0].cyc, starts[1].nib, k + 1);
         end
         n_cmp++;
         if (starts[1].cyc != r0_dones[0] + HO + 1) begin
            n_err++;
            $display("FAIL prio_holdoff: R1 start at %0d required %0d", starts[1].cyc, r0_dones[0] + HO + 1);
         end
      end
      repeat (4) @(posedge CLK);
      // R0 raised while the R1 high nibble is in flight.
      starts.delete(); r0_dones.delete(); r1_dones.delete();
      @(posedge CLK); #1;
      k = cyc;
      r1_byte = 8'h93; r1_rs = RS_CMD; r1_valid = 1'b1;
      @(posedge CLK); @(posedge CLK); #1;
      r0_nibble = 4'h6; r0_mode4bit = 1'b0; r0_read_busy = 1'b0; r0_valid = 1'b1;
      budget = 0;
      while (r0_dones.size() == 0 && budget < 150) begin @(posedge CLK); #1; budget++; end
      $display("txn priority mid-R1 req_cyc=%0d starts=%0d", k, starts.size());
      n_cmp++;
      if (starts.size() != 3 || r1_dones.size() != 1) begin
         n_err++;
         $display("FAIL prio_atomic_count: starts=%0d r1_dones=%0d required 3/1", starts.size(), r1_dones.size());
      end else begin
         n_cmp++;
         if (starts[0].nib !== 4'h9 || starts[1].nib !== 4'h3 || starts[2].nib !== 4'h6 || starts[2].cyc != r1_dones[0] + HO + 1) begin
            n_err++;
            $display("FAIL prio_atomic_order: got %h,%h,%h (R0 at %0d) required 9,3,6 (R0 at %0d)",
                     starts[0].nib, starts[1].nib, starts[2].nib, starts[2].cyc, r1_dones[0] + HO + 1);
         end
      end
      repeat (4) @(posedge CLK);
   endtask

   task automatic test_init_lockout();
      int k;
      starts.delete(); r1_dones.delete();
      resp_en = 1'b1; resp_delay = 2;
      init_done_in = 1'b0;
      @(posedge CLK); #1;
      r1_byte = 8'h2F; r1_rs = RS_DATA; r1_valid = 1'b1;
      repeat (100) @(posedge CLK);
      #1;
      n_cmp++;
      if (starts.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL init_lockout: starts=%0d busy=%0d required 0/0", starts.size(), busy);
      end
      k = cyc;
      init_done_in = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      $display("txn lockout release init_cyc=%0d starts=%0d", k, starts.size());
      n_cmp++;
      if (starts.size() < 1 || starts[0].cyc != k + 1 || starts[0].nib !== 4'h2) begin
         n_err++;
         $display("FAIL init_release: starts=%0d first_cyc=%0d required start of nibble 2 at %0d",
                  starts.size(), (starts.size() > 0) ? starts[0].cyc : -1, k + 1);
      end
      repeat (20) @(posedge CLK);
   endtask

   task automatic test_random();
      int k, d, exp_n, e_cyc, e_done;
      bit ok, use_r1;
      logic [7:0] data;
      logic rs, mode, rb, e_rs, e_mode, e_rb;
      logic [3:0] e_nib;
      init_done_in = 1'b1;
      for (int n = 0; n < 16; n++) begin
         use_r1 = 1'($urandom_range(0, 1));
         data = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         mode = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         d = $urandom_range(1, TO - 1);
         issue(use_r1, data, rs, mode, rb, d, k, ok);
         exp_n = use_r1 ? 2 : 1;
         n_cmp++;
         if (!ok || starts.size() != exp_n) begin
            n_err++;
            $display("FAIL rand_count[%0d]: done=%0d starts=%0d required done=1 starts=%0d", n, ok, starts.size(), exp_n);
         end else begin
            for (int i = 0; i < exp_n; i++) begin
               e_cyc  = k + 1 + i * (d + 1);
               e_nib  = (use_r1 && i == 0) ? data[7:4] : data[3:0];
               e_rs   = use_r1 ? rs : RS_CMD;
               e_mode = use_r1 ? 1'b1 : mode;
               e_rb   = use_r1 ? ((i == 1) ? RB_POLL : RB_NOPOLL) : rb;
               n_cmp++;
               if (starts[i].cyc != e_cyc || {starts[i].nib, starts[i].rs, starts[i].mode, starts[i].rb} !== {e_nib, e_rs, e_mode, e_rb}) begin
                  n_err++;
                  $display("FAIL rand_start[%0d.%0d]: %h/%0d/%0d/%0d@%0d required %h/%0d/%0d/%0d@%0d", n, i,
                           starts[i].nib, starts[i].rs, starts[i].mode, starts[i].rb, starts[i].cyc,
                           e_nib, e_rs, e_mode, e_rb, e_cyc);
               end
            end
            e_done = k + 1 + exp_n * (d + 1);
            n_cmp++;
            if (use_r1 ? (r1_dones.size() != 1 || r1_dones[0] != e_done || r0_dones.size() != 0)
                       : (r0_dones.size() != 1 || r0_dones[0] != e_done || r1_dones.size() != 0)) begin
               n_err++;
               $display("FAIL rand_done[%0d]: r0_dones=%0d r1_dones=%0d required one done on %s at %0d",
                        n, r0_dones.size(), r1_dones.size(), use_r1 ? "R1" : "R0", e_done);
            end
         end
      end
      n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL rand_no_error: timeout_err=%0d required 0", timeout_err);
      end
   endtask

   task automatic test_watchdog_edge();
      int k; bit ok;
      issue(1'b0, 8'h0A, RS_CMD, 1'b1, 1'b0, TO, k, ok);
      n_cmp++;
      if (!ok || r0_dones[0] != k + TO + 2 || timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL wd_edge_r0: done=%0d at %0d err=%0d required done at %0d err=0",
                  ok, ok ? r0_dones[0] : -1, timeout_err, k + TO + 2);
      end
      issue(1'b1, 8'hE7, RS_DATA, 1'b0, 1'b0, TO, k, ok);
      n_cmp++;
      if (!ok || starts.size() != 2 || r1_dones[0] != k + 1 + 2 * (TO + 1) || timeout_err !== 1'b0) begin
         n_err++;
         $display("FAIL wd_edge_r1: done=%0d starts=%0d err=%0d required done at %0d, 2 starts, err=0",
                  ok, starts.size(), timeout_err, k + 1 + 2 * (TO + 1));
      end
   endtask

   task automatic test_timeout();
      int k; bit ok;
      issue(1'b0, 8'h05, RS_CMD, 1'b0, 1'b1, 0, k, ok);
      n_cmp++;
      if (!ok || r0_dones[0] != k + TO + 2 || timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_r0: done=%0d at %0d err=%0d required done at %0d err=1",
                  ok, ok ? r0_dones[0] : -1, timeout_err, k + TO + 2);
      end
      issue(1'b1, 8'hB4, RS_DATA, 1'b0, 1'b0, 0, k, ok);
      n_cmp++;
      if (!ok || starts.size() != 1 || r1_dones[0] != k + TO + 2) begin
         n_err++;
         $display("FAIL timeout_r1_abort: done=%0d starts=%0d required done at %0d with 1 start",
                  ok, starts.size(), k + TO + 2);
      end
      repeat (30) @(posedge CLK);
      #1;
      n_cmp++;
      if (timeout_err !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_sticky: timeout_err=%0d required 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid_r1();
      int budget;
      starts.delete(); r0_dones.delete(); r1_dones.delete();
      init_done_in = 1'b1; resp_en = 1'b1; resp_delay = 3;
      @(posedge CLK); #1;
      r1_byte = 8'hA7; r1_rs = RS_CMD; r1_valid = 1'b1;
      budget = 0;
      while (starts.size() < 1 && budget < 40) begin @(posedge CLK); #1; budget++; end
      resp_en = 1'b0;
      while (starts.size() < 2 && budget < 40) begin @(posedge CLK); #1; budget++; end
      repeat (3) @(posedge CLK);
      #1;
      $display("txn R1 reset-mid-low starts=%0d", starts.size());
      n_cmp++;
      if (starts.size() != 2 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_setup: starts=%0d busy=%0d required 2/1", starts.size(), busy);
      end
      @(negedge CLK); #1;
      RESET = 1'b1;
      #1;
      n_cmp++;
      if ({tx_start, tx_nibble, tx_rs, tx_mode4bit, tx_read_busy, r0_done, r1_done, busy, timeout_err} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %b required all zero",
                  {tx_start, tx_nibble, tx_rs, tx_mode4bit, tx_read_busy, r0_done, r1_done, busy, timeout_err});
      end
      r1_valid = 1'b0; init_done_in = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      starts.delete();
      done_at = cyc + 2;
      repeat (12) @(posedge CLK);
      #1;
      n_cmp++;
      if (starts.size() != 0 || r1_dones.size() != 0 || r0_dones.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_after: starts=%0d r1_dones=%0d r0_dones=%0d busy=%0d required 0/0/0/0",
                  starts.size(), r1_dones.size(), r0_dones.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_r0_nibble();
      test_r1_byte();
      test_priority();
      test_init_lockout();
      test_random();
      test_watchdog_edge();
      test_timeout();
      test_reset_mid_r1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
